// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the MEM-stage data-memory port.
// Owns a word-organised array (byte/half/word lanes, little-endian), inserts
// WAIT_CYCLES wait states per access and raises busy so the pipeline freezes.
// Load data is right-aligned and zero-extended; err flags misaligned or
// out-of-range accesses (store suppressed, rdata=0).
//
// Ports:
//   clk, rst (async active-low)
//   req_ena/req_wena/req_wcs/req_rcs/req_addr/req_wdata : request in
//   busy  : request in progress, new requests not accepted
//   done  : one-cycle completion pulse
//   rdata : load data, valid with done, held until the next done
//   err   : one-cycle error pulse with done
//
// Optional: define DMEM_WRITE_BUFFER_EN for a one-entry posted write buffer
// with store-to-load forwarding.
module dmem_responder #(
  parameter int          ADDR_WIDTH  = 11,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_ena,
  input  logic        req_wena,
  input  logic [1:0]  req_wcs,
  input  logic [1:0]  req_rcs,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam int       DEPTH    = 1 << ADDR_WIDTH;
  localparam logic     HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [3:0] WLOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  // size encoding: 10 byte, 01 half, 00/11 word
  function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'b10:   lane_mask = 4'b0001 << a;
      2'b01:   lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // replicate right-aligned store data onto every lane it could hit
  function automatic logic [31:0] place(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b10:   place = {4{d[7:0]}};
      2'b01:   place = {2{d[15:0]}};
      default: place = d;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] sz);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (sz)
      2'b10:   extract = {24'b0, sh[7:0]};
      2'b01:   extract = a[1] ? {16'b0, w[31:16]} : {16'b0, w[15:0]};
      default: extract = w;
    endcase
  endfunction

  function automatic logic acc_err(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] off;
    logic        oor, mis;
    off = a - BASE_ADDR;  // wrap-around, so addresses below base land far out of range
    oor = |(off >> (ADDR_WIDTH + 2));
    mis = (sz == 2'b01) ? a[0] : ((sz == 2'b10) ? 1'b0 : |a[1:0]);
    acc_err = oor | mis;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] widx_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    widx_of = off[ADDR_WIDTH+1:2];
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        wena_q;
  logic        lat_en, accept;

  logic [31:0]           mem_q [DEPTH];
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx, cur_idx;
  logic [3:0]            wr_mask;
  logic [31:0]           wr_data, arr_word, ld_word;
  logic                  cur_err;

`ifdef DMEM_WRITE_BUFFER_EN
  logic                  wb_vld_q, wb_vld_d;
  logic [ADDR_WIDTH-1:0] wb_idx_q, wb_idx_d;
  logic [3:0]            wb_mask_q, wb_mask_d;
  logic [31:0]           wb_data_q, wb_data_d;
  logic                  post_q, post_d, drain_q, drain_d;

  // A full buffer stalls everything except a load, which may be served by
  // forwarding; the drain starts when no load is presented.
  assign busy = (state_q != S_IDLE) | (wb_vld_q & ~(req_ena & ~req_wena));
`else
  assign busy = (state_q != S_IDLE);
`endif

  assign accept   = req_ena & ~busy;
  assign cur_err  = acc_err(addr_q, size_q);
  assign cur_idx  = widx_of(addr_q);
  assign arr_word = mem_q[cur_idx];

`ifdef DMEM_WRITE_BUFFER_EN
  always_comb begin
    ld_word = arr_word;
    if (wb_vld_q && (wb_idx_q == cur_idx))
      for (int b = 0; b < 4; b++)
        if (wb_mask_q[b]) ld_word[8*b +: 8] = wb_data_q[8*b +: 8];
  end
`else
  assign ld_word = arr_word;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_en  = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    rdata   = rdata_q;
    wr_en   = 1'b0;
    wr_idx  = cur_idx;
    wr_mask = lane_mask(addr_q[1:0], size_q);
    wr_data = place(wdata_q, size_q);
`ifdef DMEM_WRITE_BUFFER_EN
    wb_vld_d  = wb_vld_q;
    wb_idx_d  = wb_idx_q;
    wb_mask_d = wb_mask_q;
    wb_data_d = wb_data_q;
    post_d    = post_q;
    drain_d   = drain_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          lat_en  = 1'b1;
          state_d = HAS_WAIT ? S_WAIT : S_RESP;
          cnt_d   = WLOAD;
`ifdef DMEM_WRITE_BUFFER_EN
          // clean store into an empty buffer: post it and respond next cycle
          if (req_wena && !acc_err(req_addr, req_wcs)) begin
            state_d   = S_RESP;
            post_d    = 1'b1;
            wb_vld_d  = 1'b1;
            wb_idx_d  = widx_of(req_addr);
            wb_mask_d = lane_mask(req_addr[1:0], req_wcs);
            wb_data_d = place(req_wdata, req_wcs);
          end
        end else if (wb_vld_q) begin
          state_d = HAS_WAIT ? S_WAIT : S_RESP;
          cnt_d   = WLOAD;
          drain_d = 1'b1;
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        state_d = S_IDLE;
`ifdef DMEM_WRITE_BUFFER_EN
        post_d  = 1'b0;
        drain_d = 1'b0;
        if (drain_q) begin
          wr_en    = 1'b1;
          wr_idx   = wb_idx_q;
          wr_mask  = wb_mask_q;
          wr_data  = wb_data_q;
          wb_vld_d = 1'b0;
        end else if (post_q) begin
          done  = 1'b1;
          rdata = 32'h0;
        end else
`endif
        begin
          done  = 1'b1;
          err   = cur_err;
          rdata = (cur_err || wena_q) ? 32'h0 : extract(ld_word, addr_q[1:0], size_q);
          wr_en = wena_q & ~cur_err;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      wena_q  <= 1'b0;
      rdata_q <= 32'h0;
`ifdef DMEM_WRITE_BUFFER_EN
      wb_vld_q  <= 1'b0;
      wb_idx_q  <= '0;
      wb_mask_q <= 4'b0;
      wb_data_q <= 32'h0;
      post_q    <= 1'b0;
      drain_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (lat_en) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wena_q  <= req_wena;
        size_q  <= req_wena ? req_wcs : req_rcs;
      end
      if (done) rdata_q <= rdata;
`ifdef DMEM_WRITE_BUFFER_EN
      wb_vld_q  <= wb_vld_d;
      wb_idx_q  <= wb_idx_d;
      wb_mask_q <= wb_mask_d;
      wb_data_q <= wb_data_d;
      post_q    <= post_d;
      drain_q   <= drain_d;
`endif
    end
  end

  // Array is not reset; writes only happen from RESP, which reset leaves.
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (wr_mask[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  ena = 3'b000;
  logic        req_wena = 1'b0;
  logic [1:0]  req_sz = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [2:0]  busy, done, err;
  logic [31:0] rdata [3];

  int n_tests = 0, n_fail = 0;
  int wc [3] = '{0, 3, 2};

  localparam logic [1:0] SZ_W = 2'b00, SZ_H = 2'b01, SZ_B = 2'b10;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(0)) u_d0 (
    .clk(clk), .rst(rst), .req_ena(ena[0]), .req_wena(req_wena), .req_wcs(req_sz),
    .req_rcs(req_sz), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy[0]), .done(done[0]), .rdata(rdata[0]), .err(err[0]));
  dmem_responder #(.WAIT_CYCLES(3)) u_d3 (
    .clk(clk), .rst(rst), .req_ena(ena[1]), .req_wena(req_wena), .req_wcs(req_sz),
    .req_rcs(req_sz), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy[1]), .done(done[1]), .rdata(rdata[1]), .err(err[1]));
  dmem_responder #(.WAIT_CYCLES(2)) u_d2 (
    .clk(clk), .rst(rst), .req_ena(ena[2]), .req_wena(req_wena), .req_wcs(req_sz),
    .req_rcs(req_sz), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy[2]), .done(done[2]), .rdata(rdata[2]), .err(err[2]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, act, exp);
    end
  endtask

  // cycles from accept edge to the done pulse
  function automatic int exp_lat(input int k, input logic we, input logic e);
`ifdef DMEM_WRITE_BUFFER_EN
    if (we && !e) return 1;
`endif
    return wc[k] + 1;
  endfunction

  task automatic xact(input string tag, input logic [2:0] sel, input logic we,
                      input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input bit wait_idle);
    int          lat [3];
    logic [31:0] rd  [3];
    logic        er  [3];
    bit          all;
    for (int k = 0; k < 3; k++) begin lat[k] = 0; rd[k] = 32'hx; er[k] = 1'bx; end
    @(negedge clk);
    req_wena = we; req_sz = sz; req_addr = a; req_wdata = d; ena = sel;
    @(posedge clk); #1 ena = 3'b000;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      all = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (sel[k] && lat[k] == 0 && done[k]) begin
          lat[k] = c; rd[k] = rdata[k]; er[k] = err[k];
        end
        if (sel[k] && lat[k] == 0) all = 1'b0;
      end
      if (all) break;
    end
    for (int k = 0; k < 3; k++) if (sel[k]) begin
      chk($sformatf("%s.d%0d.lat", tag, k), 32'(lat[k]), 32'(exp_lat(k, we, exp_err)));
      chk($sformatf("%s.d%0d.err", tag, k), {31'b0, er[k]}, {31'b0, exp_err});
      if (!we || exp_err) chk($sformatf("%s.d%0d.rdata", tag, k), rd[k], exp_rd);
    end
    if (wait_idle)
      for (int c = 0; c < 24; c++) begin
        if ((busy & sel) == 3'b000) break;
        @(negedge clk);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst.d%0d.busy", k), {31'b0, busy[k]}, 32'h0);
      chk($sformatf("rst.d%0d.done", k), {31'b0, done[k]}, 32'h0);
      chk($sformatf("rst.d%0d.err", k),  {31'b0, err[k]},  32'h0);
      chk($sformatf("rst.d%0d.rdata", k), rdata[k], 32'h0);
    end
    rst = 1'b1;

    // basic word store/load, then lane merging
    xact("stw",   3'b111, 1'b1, SZ_W, 32'h10010000, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    xact("ldw",   3'b111, 1'b0, SZ_W, 32'h10010000, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    xact("stb",   3'b111, 1'b1, SZ_B, 32'h10010003, 32'hFFFFFF5A, 32'h0, 1'b0, 1'b1);
    xact("ldw2",  3'b111, 1'b0, SZ_W, 32'h10010000, 32'h0, 32'h5AADBEEF, 1'b0, 1'b1);
    xact("ldh",   3'b111, 1'b0, SZ_H, 32'h10010002, 32'h0, 32'h00005AAD, 1'b0, 1'b1);
    xact("ldb",   3'b111, 1'b0, SZ_B, 32'h10010001, 32'h0, 32'h000000BE, 1'b0, 1'b1);
    xact("stw1",  3'b111, 1'b1, SZ_W, 32'h10010004, 32'h11223344, 32'h0, 1'b0, 1'b1);
    xact("sth",   3'b111, 1'b1, SZ_H, 32'h10010006, 32'h0000CAFE, 32'h0, 1'b0, 1'b1);
    xact("ldw3",  3'b111, 1'b0, SZ_W, 32'h10010004, 32'h0, 32'hCAFE3344, 1'b0, 1'b1);

    // range edges: last word in the array, first word past it
    xact("stlast", 3'b111, 1'b1, SZ_W, 32'h10011FFC, 32'h0F1E2D3C, 32'h0, 1'b0, 1'b1);
    xact("ldlast", 3'b111, 1'b0, SZ_W, 32'h10011FFC, 32'h0, 32'h0F1E2D3C, 1'b0, 1'b1);
    xact("ldoor",  3'b111, 1'b0, SZ_W, 32'h10012000, 32'h0, 32'h0, 1'b1, 1'b1);

    // errors: misaligned half load, out-of-range store (must not touch word 0)
    xact("ldmis", 3'b111, 1'b0, SZ_H, 32'h10010001, 32'h0, 32'h0, 1'b1, 1'b1);
    xact("stoor", 3'b111, 1'b1, SZ_W, 32'h00000000, 32'h01234567, 32'h0, 1'b1, 1'b1);
    xact("ldw4",  3'b111, 1'b0, SZ_W, 32'h10010000, 32'h0, 32'h5AADBEEF, 1'b0, 1'b1);

    // WAIT_CYCLES=3 timing; a request raised during busy is ignored
    @(negedge clk);
    req_wena = 1'b0; req_sz = SZ_W; req_addr = 32'h10010000; ena = 3'b010;
    @(posedge clk); #1 ena = 3'b000;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("bsy.c%0d.busy", c), {31'b0, busy[1]}, {31'b0, (c <= 4)});
      chk($sformatf("bsy.c%0d.done", c), {31'b0, done[1]}, {31'b0, (c == 4)});
      if (c == 4) chk("bsy.rdata", rdata[1], 32'h5AADBEEF);
      if (c == 2) begin req_addr = 32'h10010004; ena = 3'b010; end
      if (c == 3) ena = 3'b000;
    end
    chk("bsy.hold", rdata[1], 32'h5AADBEEF);

    // reset in the middle of a store abandons it
    xact("stold", 3'b010, 1'b1, SZ_W, 32'h10010010, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    req_wena = 1'b1; req_sz = SZ_W; req_addr = 32'h10010010; req_wdata = 32'h12345678;
    ena = 3'b010;
    @(posedge clk); #1 ena = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmid.busy", {31'b0, busy[1]}, 32'h0);
    chk("rmid.done", {31'b0, done[1]}, 32'h0);
    chk("rmid.err",  {31'b0, err[1]},  32'h0);
    chk("rmid.rdata", rdata[1], 32'h0);
    @(negedge clk);
    rst = 1'b1;
    xact("ldold", 3'b010, 1'b0, SZ_W, 32'h10010010, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1);

    // store immediately followed by a load of the same word (forwarding path
    // when the write buffer is present)
    xact("fwst", 3'b100, 1'b1, SZ_W, 32'h10010020, 32'h0BADF00D, 32'h0, 1'b0, 1'b0);
    xact("fwld", 3'b100, 1'b0, SZ_W, 32'h10010020, 32'h0, 32'h0BADF00D, 1'b0, 1'b1);
    xact("fwsb", 3'b100, 1'b1, SZ_B, 32'h10010021, 32'h000000EE, 32'h0, 1'b0, 1'b0);
    xact("fwlb", 3'b100, 1'b0, SZ_W, 32'h10010020, 32'h0, 32'h0BADEE0D, 1'b0, 1'b1);
    xact("fwl2", 3'b100, 1'b0, SZ_H, 32'h10010022, 32'h0, 32'h00000BAD, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
